vehicle_sensor_conditioner: RTL and testbench
=============================================

VEHICLE_SENSOR_CONDITIONER -- requirements
Module: vehicle_sensor_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 4, meaning consecutive high samples needed to declare a vehicle present (legal range >= 1).
REQ-002 SHALL have parameter HOLD_CYC, default 8, meaning consecutive low samples needed to declare the vehicle gone (legal range >= 1).
REQ-003 SHALL have parameter STUCK_CYC, default 1000, meaning consecutive high samples that declare the loop stuck (legal range > DEBOUNCE_CYC).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port loop_raw, input, 1 bit: asynchronous farm-road loop detector level, 1 = metal detected.
REQ-007 SHALL have port sensor, output, 1 bit, registered: conditioned vehicle request that feeds the controller's sensor input.
REQ-008 SHALL have port fault, output, 1 bit, registered: 1 while the loop is judged stuck.
REQ-009 SHALL have port vehicle_cnt, output, 16 bits, registered: count of qualified vehicle arrivals.

Function
REQ-010 SHALL synchronise loop_raw through two flops; the second flop output is loop_s, and the FSM samples loop_s once per clk.
REQ-011 SHALL implement FSM states IDLE, QUAL, PRESENT, HOLD and FAULT.
REQ-012 SHALL handle IDLE as follows: sensor=0; loop_s=1 -> QUAL with qual count=1; if DEBOUNCE_CYC=1, go directly to PRESENT.
REQ-013 SHALL handle QUAL as follows: loop_s=0 -> IDLE with count cleared; the DEBOUNCE_CYC-th consecutive high sample -> PRESENT, with sensor=1 registered on that same edge.
REQ-014 SHALL give sensor a rising latency of exactly 2+DEBOUNCE_CYC rising edges after loop_raw rises (2 synchroniser edges plus DEBOUNCE_CYC samples).
REQ-015 SHALL handle PRESENT as follows: sensor=1; loop_s=0 -> HOLD with hold count=1 (HOLD_CYC=1 -> IDLE directly).
REQ-016 SHALL handle HOLD as follows: sensor stays 1; loop_s=1 -> PRESENT with hold count cleared; the HOLD_CYC-th consecutive low sample -> IDLE, with sensor=0 on that edge.
REQ-017 SHALL drop sensor exactly 2+HOLD_CYC edges after loop_raw falls.
REQ-018 SHALL keep a stuck counter of consecutive high loop_s samples, saturating at STUCK_CYC and cleared by any low sample, in every state.
REQ-019 SHALL move from QUAL, PRESENT or HOLD to FAULT on the edge where the stuck counter reaches STUCK_CYC, with sensor=0 and fault=1 on that edge.
REQ-020 SHALL handle FAULT as follows: sensor=0 and fault=1; DEBOUNCE_CYC consecutive low samples -> IDLE with fault=0; any high sample restarts that low count.
REQ-021 SHALL increment vehicle_cnt by 1 only on a QUAL->PRESENT transition; HOLD->PRESENT re-entry does not count; the counter wraps from 0xFFFF to 0x0000.
REQ-022 SHALL size each internal counter at $clog2(param+1) bits, with no overflow at the parameter maximum.
REQ-023 SHALL give the stuck condition priority over the debounce and hold decisions when both occur on the same edge.
REQ-024 SHALL never assert sensor and fault in the same cycle.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously clear both synchroniser flops, set the FSM to IDLE, and clear all counters, sensor, fault and vehicle_cnt.
REQ-026 SHALL, if reset is asserted mid-operation in any state, abandon that operation with no residual count; after release, qualification restarts from IDLE.
REQ-027 SHALL deassert rst_n synchronously to clk externally; the block adds no reset synchroniser.

Structure
REQ-028 SHALL define the FSM state enum (IDLE, QUAL, PRESENT, HOLD, FAULT) in shared package tlc_pkg.
REQ-029 SHALL place the light-code constants GREEN=2'b00, YELLOW=2'b01 and RED=2'b10 in tlc_pkg, shared with the controller.
REQ-030 SHALL implement the two-flop synchroniser as sub-module sync_2ff (1-bit, async active-low clear), instantiated once.

Verification (bench parameters DEBOUNCE_CYC=4, HOLD_CYC=8, STUCK_CYC=64)
REQ-031 SHALL verify a clean arrival: loop_raw held high -> sensor rises at edge 6, vehicle_cnt goes 0->1 on the same edge, fault stays 0.
REQ-032 SHALL verify glitch rejection: loop_raw high for 3 cycles then low -> sensor stays 0, vehicle_cnt stays 0, FSM returns to IDLE.
REQ-033 SHALL verify a hold gap: in PRESENT, drop loop_raw for 5 cycles then raise it -> sensor stays 1 throughout, vehicle_cnt is unchanged; a later low for 8+ cycles -> sensor falls at edge 10 after the drop.
REQ-034 SHALL verify the stuck loop: loop_raw held high for 80 cycles -> sensor=1 from edge 6; at edge 66, sensor=0 and fault=1; then loop_raw low -> fault=0 at edge 6 after the drop, sensor stays 0.
REQ-035 SHALL verify reset mid-operation: assert rst_n=0 while in HOLD with vehicle_cnt=3 -> sensor=0, fault=0 and vehicle_cnt=0 immediately, without waiting for clk; after release with loop_raw high, sensor rises at edge 6.
REQ-036 SHALL verify wrap-around: preload the count via 65535 qualified arrivals, then apply one more arrival -> vehicle_cnt=0x0000.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light controller slice: the loop-sensor
// FSM state encoding and the light codes used by the controller.
package tlc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      QUAL,
      PRESENT,
      HOLD,
      FAULT
   } sensor_state_t;

   localparam logic [1:0] GREEN  = 2'b00;
   localparam logic [1:0] YELLOW = 2'b01;
   localparam logic [1:0] RED    = 2'b10;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, cleared by reset.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops; the first may go metastable, the second settles it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/vehicle_sensor_conditioner.sv
// Farm-road loop conditioner: synchronises the raw loop level, debounces
// arrivals, holds the request across short gaps, flags a stuck loop and
// counts qualified vehicle arrivals.
module vehicle_sensor_conditioner
   import tlc_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 4,
   parameter int HOLD_CYC     = 8,
   parameter int STUCK_CYC    = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        loop_raw,
   output logic        sensor,
   output logic        fault,
   output logic [15:0] vehicle_cnt
);

   localparam int QW = $clog2(DEBOUNCE_CYC + 1);
   localparam int HW = $clog2(HOLD_CYC + 1);
   localparam int SW = $clog2(STUCK_CYC + 1);

   localparam logic [QW-1:0] QUAL_LAST = QW'(DEBOUNCE_CYC - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
   localparam logic [SW-1:0] STK_LAST  = SW'(STUCK_CYC - 1);
   localparam logic [SW-1:0] STK_MAX   = SW'(STUCK_CYC);

   logic          loop_s;
   logic          stuck_hit;
   sensor_state_t state;
   logic [QW-1:0] qual_cnt;
   logic [HW-1:0] hold_cnt;
   logic [SW-1:0] stuck_cnt;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (loop_raw),
      .q     (loop_s)
   );

   // The stuck counter reaches its limit on this edge.
   assign stuck_hit = loop_s && (stuck_cnt == STK_LAST);

   // Run length of consecutive high samples, saturating at the stuck limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stuck_cnt <= '0;
      end else if (!loop_s) begin
         stuck_cnt <= '0;
      end else if (stuck_cnt != STK_MAX) begin
         stuck_cnt <= stuck_cnt + SW'(1);
      end
   end

   // Presence FSM with registered sensor/fault outputs and arrival counter.
   // qual_cnt doubles as the low-sample counter while in FAULT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         qual_cnt    <= '0;
         hold_cnt    <= '0;
         sensor      <= 1'b0;
         fault       <= 1'b0;
         vehicle_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               sensor <= 1'b0;
               fault  <= 1'b0;
               if (loop_s) begin
                  if (DEBOUNCE_CYC == 1) begin
                     // Single-sample debounce: the qualification completes here.
                     state       <= PRESENT;
                     sensor      <= 1'b1;
                     qual_cnt    <= '0;
                     vehicle_cnt <= vehicle_cnt + 16'd1;
                  end else begin
                     state    <= QUAL;
                     qual_cnt <= QW'(1);
                  end
               end
            end

            QUAL: begin
               if (stuck_hit) begin
                  state    <= FAULT;
                  sensor   <= 1'b0;
                  fault    <= 1'b1;
                  qual_cnt <= '0;
               end else if (!loop_s) begin
                  state    <= IDLE;
                  qual_cnt <= '0;
               end else if (qual_cnt == QUAL_LAST) begin
                  state       <= PRESENT;
                  sensor      <= 1'b1;
                  qual_cnt    <= '0;
                  vehicle_cnt <= vehicle_cnt + 16'd1;
               end else begin
                  qual_cnt <= qual_cnt + QW'(1);
               end
            end

            PRESENT: begin
               if (stuck_hit) begin
                  state    <= FAULT;
                  sensor   <= 1'b0;
                  fault    <= 1'b1;
                  qual_cnt <= '0;
                  hold_cnt <= '0;
               end else if (!loop_s) begin
                  if (HOLD_CYC == 1) begin
                     state  <= IDLE;
                     sensor <= 1'b0;
                  end else begin
                     state    <= HOLD;
                     hold_cnt <= HW'(1);
                  end
               end
            end

            HOLD: begin
               if (stuck_hit) begin
                  state    <= FAULT;
                  sensor   <= 1'b0;
                  fault    <= 1'b1;
                  qual_cnt <= '0;
                  hold_cnt <= '0;
               end else if (loop_s) begin
                  state    <= PRESENT;
                  hold_cnt <= '0;
               end else if (hold_cnt == HOLD_LAST) begin
                  state    <= IDLE;
                  sensor   <= 1'b0;
                  hold_cnt <= '0;
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end

            FAULT: begin
               sensor <= 1'b0;
               fault  <= 1'b1;
               if (loop_s) begin
                  qual_cnt <= '0;
               end else if (qual_cnt == QUAL_LAST) begin
                  state    <= IDLE;
                  fault    <= 1'b0;
                  qual_cnt <= '0;
               end else begin
                  qual_cnt <= qual_cnt + QW'(1);
               end
            end

            default: begin
               state    <= IDLE;
               sensor   <= 1'b0;
               fault    <= 1'b0;
               qual_cnt <= '0;
               hold_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// Bench for vehicle_sensor_conditioner: vector table, directed multi-cycle
// sequences and randomized runs against a run-length reference model.
module tb_vehicle_sensor_conditioner;

   localparam int D = 4;
   localparam int H = 8;
   localparam int S = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        loop_raw = 1'b0;
   logic        sensor;
   logic        fault;
   logic [15:0] vehicle_cnt;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic        raw;
      logic        s;
      logic        f;
      logic [15:0] c;
   } vec_t;

   vec_t tbl[$];

   // Reference model state: raw-sample pipeline and run lengths of loop_s.
   logic        m_p1, m_p2;
   int          m_high, m_low;
   logic        m_present, m_fault;
   logic [15:0] m_cnt;

   vehicle_sensor_conditioner #(
      .DEBOUNCE_CYC (D),
      .HOLD_CYC     (H),
      .STUCK_CYC    (S)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .loop_raw    (loop_raw),
      .sensor      (sensor),
      .fault       (fault),
      .vehicle_cnt (vehicle_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic es, input logic ef, input logic [15:0] ec);
      total++;
      if (sensor !== es || fault !== ef || vehicle_cnt !== ec) begin
         bad++;
         $display("FAIL %s t=%0t: got sensor=%0b fault=%0b cnt=%0d, want sensor=%0b fault=%0b cnt=%0d",
                  nm, $time, sensor, fault, vehicle_cnt, es, ef, ec);
      end
   endtask

   task automatic model_reset();
      m_p1 = 1'b0; m_p2 = 1'b0;
      m_high = 0; m_low = 0;
      m_present = 1'b0; m_fault = 1'b0;
      m_cnt = '0;
   endtask

   // One clock edge seen by the model; loop_s lags the raw level by two edges.
   task automatic model_edge(input logic raw);
      logic s;
      int   prev_high;
      s = m_p2;
      m_p2 = m_p1;
      m_p1 = raw;
      prev_high = m_high;
      if (s) begin
         m_low = 0;
         if (m_high < S) m_high++;
      end else begin
         m_high = 0;
         if (m_low < 1000000) m_low++;
      end
      if (m_fault) begin
         if (!s && m_low == D) m_fault = 1'b0;
      end else if (s && prev_high == S - 1) begin
         m_fault = 1'b1;
         m_present = 1'b0;
      end else if (!m_present) begin
         if (s && m_high == D) begin
            m_present = 1'b1;
            m_cnt = m_cnt + 16'd1;
         end
      end else if (!s && m_low == H) begin
         m_present = 1'b0;
      end
   endtask

   task automatic step(input logic raw);
      loop_raw = raw;
      @(posedge clk);
      model_edge(raw);
      #1;
   endtask

   task automatic do_reset();
      loop_raw = 1'b0;
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
   endtask

   function automatic void add(input logic raw, input logic s, input logic f, input logic [15:0] c);
      vec_t v;
      v.raw = raw; v.s = s; v.f = f; v.c = c;
      tbl.push_back(v);
   endfunction

   initial begin
      int cyc;
      int len;
      logic lvl;

      // Clean arrival, 5-cycle gap, drop; glitch; second arrival and drop.
      for (int i = 0;  i < 10; i++) add(1'b1, i >= 5, 1'b0, (i >= 5) ? 16'd1 : 16'd0);
      for (int i = 10; i < 15; i++) add(1'b0, 1'b1, 1'b0, 16'd1);
      for (int i = 15; i < 20; i++) add(1'b1, 1'b1, 1'b0, 16'd1);
      for (int i = 20; i < 32; i++) add(1'b0, i < 29, 1'b0, 16'd1);
      for (int i = 32; i < 35; i++) add(1'b1, 1'b0, 1'b0, 16'd1);
      for (int i = 35; i < 43; i++) add(1'b0, 1'b0, 1'b0, 16'd1);
      for (int i = 43; i < 49; i++) add(1'b1, i >= 48, 1'b0, (i >= 48) ? 16'd2 : 16'd1);
      for (int i = 49; i < 61; i++) add(1'b0, i < 58, 1'b0, 16'd2);

      // Asynchronous reset takes effect before any clock edge.
      model_reset();
      #1 rst_n = 1'b0;
      #1 chk("reset_async", 1'b0, 1'b0, 16'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk("reset_release", 1'b0, 1'b0, 16'd0);

      foreach (tbl[i]) begin
         step(tbl[i].raw);
         chk($sformatf("table[%0d]", i), tbl[i].s, tbl[i].f, tbl[i].c);
      end

      // Stuck loop: held high 80 cycles, then released.
      do_reset();
      for (int k = 1; k <= 80; k++) begin
         step(1'b1);
         chk($sformatf("stuck_hi[%0d]", k), (k >= 6) && (k < 66), k >= 66, (k >= 6) ? 16'd1 : 16'd0);
      end
      for (int j = 1; j <= 10; j++) begin
         step(1'b0);
         chk($sformatf("stuck_lo[%0d]", j), 1'b0, j < 6, 16'd1);
      end

      // Reset while in HOLD with three arrivals counted.
      do_reset();
      for (int a = 0; a < 2; a++) begin
         for (int k = 0; k < 6; k++) step(1'b1);
         for (int k = 0; k < 10; k++) step(1'b0);
      end
      for (int k = 0; k < 6; k++) step(1'b1);
      for (int k = 0; k < 4; k++) step(1'b0);
      chk("pre_reset_hold", 1'b1, 1'b0, 16'd3);
      loop_raw = 1'b1;
      #2 rst_n = 1'b0;
      #1 chk("midop_reset", 1'b0, 1'b0, 16'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      for (int k = 1; k <= 8; k++) begin
         step(1'b1);
         chk($sformatf("after_rst[%0d]", k), k >= 6, 1'b0, (k >= 6) ? 16'd1 : 16'd0);
      end
      for (int k = 0; k < 10; k++) step(1'b0);

      // Counter wrap: preload near the top, then two arrivals.
      @(negedge clk);
      force dut.vehicle_cnt = 16'hFFFE;
      @(negedge clk);
      release dut.vehicle_cnt;
      for (int k = 1; k <= 6; k++) step(1'b1);
      chk("wrap_ffff", 1'b1, 1'b0, 16'hFFFF);
      for (int k = 0; k < 10; k++) step(1'b0);
      for (int k = 1; k <= 6; k++) begin
         step(1'b1);
         chk($sformatf("wrap_arrive[%0d]", k), k >= 6, 1'b0, (k >= 6) ? 16'h0000 : 16'hFFFF);
      end

      // Randomized level runs, occasionally long enough to trip the stuck detector.
      do_reset();
      cyc = 0;
      lvl = 1'b0;
      while (cyc < 4000) begin
         lvl = ~lvl;
         if (lvl && $urandom_range(0, 7) == 0) len = int'($urandom_range(60, 75));
         else len = int'($urandom_range(1, 12));
         for (int k = 0; k < len; k++) begin
            step(lvl);
            chk("random", m_present, m_fault, m_cnt);
            cyc++;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
